// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module : cpu_pkg
//  Brief  : Shared opcodes, IR field positions, T-state encoding and the
//           instruction-class record for the hardwired control sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int OP_W   = 5;
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_e;

    typedef struct packed {
        logic is_alu_reg;
        logic is_alu_imm;
        logic is_ld;
        logic is_st;
        logic is_muldiv;
        logic is_nop;
        logic is_halt;
        logic is_illegal;
    } iclass_t;

    function automatic logic [OP_W-1:0] op_of(input logic [31:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/instr_class_decode.sv
`default_nettype none
// ============================================================================
//  Module : instr_class_decode
//  Brief  : Combinational opcode to one-hot instruction-class decode.
//  Rev    : 1.0  initial release
// ============================================================================
module instr_class_decode
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output iclass_t         cls_o
);

    always_comb begin
        cls_o = '0;
        unique case (op_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR: cls_o.is_alu_reg = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI:      cls_o.is_alu_imm = 1'b1;
            OP_LD:                         cls_o.is_ld      = 1'b1;
            OP_ST:                         cls_o.is_st      = 1'b1;
            OP_MUL, OP_DIV:                cls_o.is_muldiv  = 1'b1;
            OP_NOP:                        cls_o.is_nop     = 1'b1;
            OP_HALT:                       cls_o.is_halt    = 1'b1;
            default:                       cls_o.is_illegal = 1'b1;
        endcase
    end

endmodule : instr_class_decode
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : control_sequencer
//  Brief  : Hardwired T-state fetch/decode/execute control unit driving the
//           bus datapath strobes, with memory-ready stall and timeout halt.
//  Rev    : 1.0  initial release
// ============================================================================
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int OPW         = OP_W
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [31:0]    ir,
    input  logic           mem_ready,
    input  logic           stop,
    output logic           PCout,
    output logic           PCin,
    output logic           IncPC,
    output logic           MARin,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Yin,
    output logic           Zin,
    output logic           Zlowout,
    output logic           Zhighout,
    output logic           HIin,
    output logic           LOin,
    output logic           Read,
    output logic           Write,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic           BAout,
    output logic           Cout,
    output logic [OPW-1:0] alu_op,
    output logic           run,
    output logic           illegal_op,
    output logic           bus_error
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] C_TMO_LAST = CW'(MEM_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   tcnt_q, tcnt_d;
    logic            berr_q, berr_d;

    logic [OP_W-1:0] w_op;
    iclass_t         w_cls;
    logic            w_wait;
    logic            w_tmo;
    logic            w_unused_ir;

    assign w_op        = op_of(ir);
    // Operand fields are consumed by the datapath's register-select logic.
    assign w_unused_ir = ^ir[OP_LSB-1:0];

    instr_class_decode u_dec (
        .op_i  (w_op),
        .cls_o (w_cls)
    );

    assign w_wait = (state_q == ST_T1)
                  | ((state_q == ST_T6) & w_cls.is_ld)
                  | ((state_q == ST_T7) & w_cls.is_st);
    assign w_tmo  = w_wait & ~mem_ready & (tcnt_q == C_TMO_LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_RST;
            tcnt_q  <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            berr_q  <= berr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = '0;
        berr_d  = berr_q;
        if (w_wait && !mem_ready) begin
            if (w_tmo) begin
                berr_d  = 1'b1;
                state_d = ST_HALT;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_RST:  state_d = ST_T0;
                ST_T0:   state_d = stop ? ST_T0 : ST_T1;
                ST_T1:   state_d = ST_T2;
                ST_T2:   state_d = ST_T3;
                ST_T3: begin
                    if (w_cls.is_halt)
                        state_d = ST_HALT;
                    else if (w_cls.is_nop || w_cls.is_illegal)
                        state_d = ST_T0;
                    else
                        state_d = ST_T4;
                end
                ST_T4:   state_d = ST_T5;
                ST_T5:   state_d = (w_cls.is_alu_reg || w_cls.is_alu_imm) ? ST_T0 : ST_T6;
                ST_T6:   state_d = (w_cls.is_ld || w_cls.is_st) ? ST_T7 : ST_T0;
                ST_T7:   state_d = ST_T0;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_RST;
            endcase
        end
    end

    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
        Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; HIin = 1'b0;
        LOin = 1'b0; Read = 1'b0; Write = 1'b0; Gra = 1'b0;
        Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; Cout = 1'b0;
        alu_op     = '0;
        illegal_op = 1'b0;
        unique case (state_q)
            ST_T0: begin
                if (!stop) begin
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                end
            end
            ST_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            ST_T3: begin
                if (w_cls.is_alu_reg || w_cls.is_alu_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (w_cls.is_ld || w_cls.is_st) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (w_cls.is_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end
                illegal_op = w_cls.is_illegal;
            end
            ST_T4: begin
                Zin = 1'b1;
                if (w_cls.is_alu_reg) begin
                    Grc = 1'b1; Rout = 1'b1; alu_op = OPW'(w_op);
                end else if (w_cls.is_alu_imm) begin
                    Cout = 1'b1; alu_op = OPW'(w_op);
                end else if (w_cls.is_ld || w_cls.is_st) begin
                    // Effective address is always formed with an add.
                    Cout = 1'b1; alu_op = OPW'(OP_ADD);
                end else if (w_cls.is_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; alu_op = OPW'(w_op);
                end
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (w_cls.is_alu_reg || w_cls.is_alu_imm) begin
                    Gra = 1'b1; Rin = 1'b1;
                end else if (w_cls.is_ld || w_cls.is_st) begin
                    MARin = 1'b1;
                end else if (w_cls.is_muldiv) begin
                    LOin = 1'b1;
                end
            end
            ST_T6: begin
                if (w_cls.is_ld) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (w_cls.is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (w_cls.is_muldiv) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end
            end
            ST_T7: begin
                if (w_cls.is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_cls.is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign run       = (state_q != ST_HALT);
    assign bus_error = berr_q;

endmodule : control_sequencer
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : tb_control_sequencer
//  Brief  : Table-driven scoreboard bench for the hardwired control sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] ir = '0;
    logic        mem_ready = 1'b0;
    logic        stop = 1'b0;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
    logic Zhighout, HIin, LOin, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic [4:0] alu_op;
    logic run, illegal_op, bus_error;

    always #5 clk = ~clk;

    control_sequencer #(.MEM_TIMEOUT(16), .OPW(5)) dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .stop(stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .alu_op(alu_op), .run(run), .illegal_op(illegal_op),
        .bus_error(bus_error)
    );

    localparam logic [21:0] S_PCOUT = 22'b1 << 21, S_PCIN  = 22'b1 << 20, S_INCPC = 22'b1 << 19;
    localparam logic [21:0] S_MARIN = 22'b1 << 18, S_MDRIN = 22'b1 << 17, S_MDROUT = 22'b1 << 16;
    localparam logic [21:0] S_IRIN  = 22'b1 << 15, S_YIN   = 22'b1 << 14, S_ZIN   = 22'b1 << 13;
    localparam logic [21:0] S_ZLO   = 22'b1 << 12, S_ZHI   = 22'b1 << 11, S_HIIN  = 22'b1 << 10;
    localparam logic [21:0] S_LOIN  = 22'b1 << 9,  S_READ  = 22'b1 << 8,  S_WRITE = 22'b1 << 7;
    localparam logic [21:0] S_GRA   = 22'b1 << 6,  S_GRB   = 22'b1 << 5,  S_GRC   = 22'b1 << 4;
    localparam logic [21:0] S_RIN   = 22'b1 << 3,  S_ROUT  = 22'b1 << 2,  S_BAOUT = 22'b1 << 1;
    localparam logic [21:0] S_COUT  = 22'b1 << 0;

    localparam logic [21:0] F0 = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
    localparam logic [21:0] F1 = S_ZLO | S_PCIN | S_READ | S_MDRIN;
    localparam logic [21:0] F2 = S_MDROUT | S_IRIN;

    localparam logic [31:0] I_ADD  = 32'h1891_8000;
    localparam logic [31:0] I_LD   = 32'h0088_0010;
    localparam logic [31:0] I_ST   = 32'h1088_0020;
    localparam logic [31:0] I_ADDI = 32'h6088_0005;
    localparam logic [31:0] I_MUL  = 32'h7888_0000;
    localparam logic [31:0] I_NOP  = 32'hD000_0000;
    localparam logic [31:0] I_HALT = 32'hD800_0000;
    localparam logic [31:0] I_ILL  = 32'hF800_0000;

    localparam logic [29:0] C_EXP_RST  = {22'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    localparam logic [29:0] C_EXP_WAIT = {F1,    5'd0, 1'b1, 1'b0, 1'b0};
    localparam logic [29:0] C_EXP_TMO  = {22'b0, 5'd0, 1'b0, 1'b0, 1'b1};

    typedef struct {
        logic        clr;
        logic [31:0] ir;
        logic        mr;
        logic        stop;
        logic [29:0] exp;
        logic        chk;
    } vec_t;

    vec_t        tbl[$];
    logic [29:0] sb[$];
    int          n_vec = 0;
    int          n_bad = 0;

    logic [29:0] w_obs;
    assign w_obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
                    Zhighout, HIin, LOin, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
                    Cout, alu_op, run, illegal_op, bus_error};

    function automatic void a(input logic [31:0] i, input logic [21:0] s,
                              input logic [4:0] op = 5'd0, input logic m = 1'b1,
                              input logic st = 1'b0, input logic rn = 1'b1,
                              input logic ill = 1'b0, input logic be = 1'b0,
                              input logic c = 1'b0, input logic chk = 1'b1);
        vec_t v;
        v.clr = c; v.ir = i; v.mr = m; v.stop = st;
        v.exp = {s, op, rn, ill, be};
        v.chk = chk;
        tbl.push_back(v);
    endfunction

    function automatic void fetch(input logic [31:0] i);
        a(i, F0); a(i, F1); a(i, F2);
    endfunction

    initial begin
        // Power-up clear, then add R1,R2,R3
        a(I_ADD, '0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        a(I_ADD, '0);
        fetch(I_ADD);
        a(I_ADD, S_GRB | S_ROUT | S_YIN);
        a(I_ADD, S_GRC | S_ROUT | S_ZIN, 5'b00011);
        a(I_ADD, S_ZLO | S_GRA | S_RIN);
        // ld with three memory stall cycles at T6
        fetch(I_LD);
        a(I_LD, S_GRB | S_BAOUT | S_YIN);
        a(I_LD, S_COUT | S_ZIN, 5'b00011);
        a(I_LD, S_ZLO | S_MARIN);
        for (int k = 0; k < 3; k++) a(I_LD, S_READ | S_MDRIN, 5'd0, 1'b0);
        a(I_LD, S_READ | S_MDRIN);
        a(I_LD, S_MDROUT | S_GRA | S_RIN);
        // Undefined opcode
        fetch(I_ILL);
        a(I_ILL, '0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        // addi
        fetch(I_ADDI);
        a(I_ADDI, S_GRB | S_ROUT | S_YIN);
        a(I_ADDI, S_COUT | S_ZIN, 5'b01100);
        a(I_ADDI, S_ZLO | S_GRA | S_RIN);
        // mul
        fetch(I_MUL);
        a(I_MUL, S_GRA | S_ROUT | S_YIN);
        a(I_MUL, S_GRB | S_ROUT | S_ZIN, 5'b01111);
        a(I_MUL, S_ZLO | S_LOIN);
        a(I_MUL, S_ZHI | S_HIIN);
        // st with one write stall
        fetch(I_ST);
        a(I_ST, S_GRB | S_BAOUT | S_YIN);
        a(I_ST, S_COUT | S_ZIN, 5'b00011);
        a(I_ST, S_ZLO | S_MARIN);
        a(I_ST, S_GRA | S_ROUT | S_MDRIN);
        a(I_ST, S_WRITE, 5'd0, 1'b0);
        a(I_ST, S_WRITE);
        // Ready arriving on the last allowed wait cycle still wins
        a(I_NOP, F0);
        for (int k = 0; k < 15; k++) a(I_NOP, F1, 5'd0, 1'b0);
        a(I_NOP, F1);
        a(I_NOP, F2);
        a(I_NOP, '0);
        // Memory timeout in T1 -> sticky bus_error and halt
        a(I_NOP, F0);
        for (int k = 0; k < 16; k++) a(I_NOP, F1, 5'd0, 1'b0);
        a(I_NOP, '0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        a(I_NOP, '0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        a(I_NOP, '0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        a(I_HALT, '0);
        // halt opcode
        fetch(I_HALT);
        a(I_HALT, '0);
        a(I_HALT, '0, 5'd0, 1'b1, 1'b1, 1'b0);
        a(I_HALT, '0, 5'd0, 1'b0, 1'b0, 1'b0);
        a(I_HALT, '0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        a(I_ST, '0);
        // clr during st T6 aborts before Write; stop holds T0
        fetch(I_ST);
        a(I_ST, S_GRB | S_BAOUT | S_YIN);
        a(I_ST, S_COUT | S_ZIN, 5'b00011);
        a(I_ST, S_ZLO | S_MARIN);
        a(I_ST, S_GRA | S_ROUT | S_MDRIN, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        a(I_ST, '0);
        a(I_ST, '0, 5'd0, 1'b1, 1'b1);
        a(I_ST, '0, 5'd0, 1'b1, 1'b1);
        a(I_ST, F0);
        a(I_ST, F1);

        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk);
            #1;
            clr       = tbl[k].clr;
            ir        = tbl[k].ir;
            mem_ready = tbl[k].mr;
            stop      = tbl[k].stop;
            if (tbl[k].chk) sb.push_back(tbl[k].exp);
            @(negedge clk);
            if (tbl[k].chk) begin
                logic [29:0] e;
                e = sb.pop_front();
                n_vec++;
                if (w_obs !== e) begin
                    n_bad++;
                    $display("FAIL vec %0d: got %b required %b (strobes|alu_op|run|ill|berr)",
                             k, w_obs, e);
                end
            end
        end

        // Directed reset-state check
        @(posedge clk);
        #1;
        clr       = 1'b1;
        ir        = I_NOP;
        mem_ready = 1'b1;
        stop      = 1'b0;
        @(posedge clk);
        #1;
        clr       = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (w_obs !== C_EXP_RST) begin
            n_bad++;
            $display("FAIL reset state: got %b required %b", w_obs, C_EXP_RST);
        end

        // Directed expired-wait check: T1 with mem_ready stuck low
        repeat (17) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (w_obs !== C_EXP_WAIT) begin
            n_bad++;
            $display("FAIL last wait cycle: got %b required %b", w_obs, C_EXP_WAIT);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (w_obs !== C_EXP_TMO) begin
            n_bad++;
            $display("FAIL expired wait: got %b required %b", w_obs, C_EXP_TMO);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_control_sequencer
`default_nettype wire
